// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle multiply/divide unit with HI/LO registers
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [4:0]       count;
   logic             is_div;
   logic             neg_q;      // quotient / product must be negated
   logic             neg_r;      // remainder must be negated (dividend negative)
   logic [WIDTH-1:0] a_r;        // raw dividend, returned as remainder on divide by zero
   logic [WIDTH-1:0] mag_b;      // multiplicand / divisor magnitude
   logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
   logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits then quotient bits

   logic [WIDTH-1:0] mag_a_in;
   logic [WIDTH-1:0] mag_b_in;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             q_bit;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   // Operand magnitudes, one iteration of shift-add / restoring divide, and sign-corrected final result
   always_comb begin
      mag_a_in = (op[0] && src_a[WIDTH-1]) ? (-src_a) : src_a;
      mag_b_in = (op[0] && src_b[WIDTH-1]) ? (-src_b) : src_b;

      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      q_bit     = ~div_diff[WIDTH];

      if (is_div) begin
         step_hi = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], q_bit};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end

      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? (-prod) : prod;

      if (!is_div) begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end else if (mag_b == '0) begin
         res_hi = a_r;
         res_lo = '1;
      end else begin
         res_hi = neg_r ? (-step_hi) : step_hi;
         res_lo = neg_q ? (-step_lo) : step_lo;
      end
   end

   // Control FSM, iteration datapath registers and the architectural HI/LO registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         count  <= 5'd0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         a_r    <= '0;
         mag_b  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  is_div <= op[1];
                  neg_q  <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r  <= op[0] & src_a[WIDTH-1];
                  a_r    <= src_a;
                  mag_b  <= mag_b_in;
                  acc_hi <= '0;
                  acc_lo <= mag_a_in;
                  count  <= 5'd0;
                  state  <= ST_RUN;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            ST_RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count + 5'd1;
               if (count == 5'd31) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;
   logic [63:0] sb[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int first_d;
   int second_d;
   int low_n;
   int d_cnt;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected result
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%h_%h required=no_result", hi, lo);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("result_hi", hi, e[63:32]);
            chk("result_lo", lo, e[31:0]);
         end
      end
   end

   // Issue one operation from a negedge; returns at the negedge where busy has fallen
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit lo_we_run, input bit hi_we_start);
      int busy_n = 0;
      int done_n = 0;
      op = o; src_a = a; src_b = b; start = 1'b1;
      hi_we = hi_we_start; wdata = 32'hDEADBEEF;
      sb.push_back({eh, el});
      @(posedge clk);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0; hi_we = 1'b0;
            chk("hold_hi_at_start", hi, m_hi);
            chk("hold_lo_at_start", lo, m_lo);
         end
         if (busy) busy_n++;
         if (done) done_n++;
         if (!busy) break;
         if (i == 5 && lo_we_run) begin lo_we = 1'b1; wdata = 32'hCAFEF00D; end
         if (i == 6) lo_we = 1'b0;
         if (i == 10) begin src_a = 32'h0; src_b = $urandom; op = ~o; end
      end
      chk("busy_cycles", busy_n, 33);
      chk("done_cycles", done_n, 1);
      m_hi = eh; m_lo = el;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      reset = 1'b1;

      // MTHI alone, then MTHI+MTLO together
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_lo", lo, 32'h0);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mtboth_hi", hi, 32'hA5A5A5A5);
      chk("mtboth_lo", lo, 32'hA5A5A5A5);
      m_hi = 32'hA5A5A5A5; m_lo = 32'hA5A5A5A5;

      do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
      do_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
      do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
      do_op(2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b0);
      do_op(2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b0, 1'b0);
      do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
      do_op(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
      do_op(2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b0, 1'b0);
      do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
      do_op(2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0);

      // Back-to-back with start held high: second op latched 100/7 only after DONE
      op = 2'b10; src_a = 32'd7; src_b = 32'd2; start = 1'b1;
      sb.push_back({32'd1, 32'd3});
      sb.push_back({32'd2, 32'd14});
      first_d = 0; second_d = 0; low_n = 0;
      @(posedge clk);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (done) begin
            if (first_d == 0) first_d = i;
            else begin second_d = i; start = 1'b0; end
         end
         if (first_d != 0 && second_d == 0 && !busy) low_n++;
         if (i == 10) begin src_a = 32'd100; src_b = 32'd7; end
         if (second_d != 0 && !busy) break;
      end
      start = 1'b0;
      chk("b2b_first_done", first_d, 33);
      chk("b2b_second_done", second_d, 67);
      chk("b2b_idle_gap", low_n, 1);
      m_hi = 32'd2; m_lo = 32'd14;

      // Reset during RUN iteration 10
      op = 2'b00; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
      sb.push_back({32'd0, 32'd15});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_rst_busy", {31'b0, busy}, 32'd0);
      chk("async_rst_done", {31'b0, done}, 32'd0);
      chk("async_rst_hi", hi, 32'h0);
      chk("async_rst_lo", lo, 32'h0);
      #1;
      reset = 1'b1;
      sb.delete();
      d_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) d_cnt++;
      end
      chk("no_activity_after_rst", d_cnt, 0);
      m_hi = '0; m_lo = '0;
      do_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
